// File: rtl/uart_pkg.sv
// Shared definitions for the UART subsystem.
//   BAUD_RATE   : rate table indexed by the 3-bit baud select
//   PAR_*       : parity mode encodings
//   tx_state_e  : transmitter frame state
//   baud_div    : clock cycles per bit cell for a given select and clock
//   parity_bit  : parity bit over the low nbits of a character
package uart_pkg;

  localparam int unsigned BAUD_RATE [0:7] = '{
    32'd300, 32'd1200, 32'd4800, 32'd9600,
    32'd19200, 32'd38400, 32'd57600, 32'd115200
  };

  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_EVEN = 32'sd1;
  localparam int PAR_ODD  = 32'sd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // A zero divisor (clock slower than the baud rate) would never tick,
  // so it is clamped to one cycle per cell.
  function automatic logic [31:0] baud_div(input logic [2:0] sel,
                                           input int unsigned clk_freq);
    logic [31:0] raw;
    raw = clk_freq / BAUD_RATE[sel];
    return (raw == 32'd0) ? 32'd1 : raw;
  endfunction

  function automatic logic parity_bit(input logic [8:0] data,
                                      input int unsigned nbits,
                                      input int mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) begin
        p = p ^ data[i];
      end else begin
        p = p;
      end
    end
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-cell timer for the UART transmitter.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_load       : frame start; latches i_div and restarts the cell count
//   i_run        : a frame is in progress
//   i_div        : cycles per bit cell
//   o_bit_tick   : high in the last cycle of every bit cell
module uart_baud_gen (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_run,
  input  logic [31:0] i_div,
  output logic        o_bit_tick
);

  logic [31:0] r_div;
  logic [31:0] r_cnt;

  assign o_bit_tick = i_run & (r_cnt == (r_div - 32'd1));

  // Divisor latch and per-cell cycle counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= 32'd0;
      r_cnt <= 32'd0;
    end else if (i_load) begin
      r_div <= i_div;
      r_cnt <= 32'd0;
    end else if (o_bit_tick || !i_run) begin
      r_cnt <= 32'd0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a DEPTH-entry FIFO feeding a frame serialiser.
//   clk, reset   : clock, asynchronous active-high reset
//   Tx_en        : allows a new frame to start
//   Tx_wr        : one-cycle write strobe for Tx_data
//   Tx_data      : character to queue
//   baud_sel     : rate index, latched at frame start
//   Tx_D         : serial line, idles high
//   Tx_busy      : frame in progress
//   Tx_full      : FIFO holds DEPTH entries
//   Tx_empty     : FIFO holds no entries
//   Tx_level     : FIFO occupancy 0..DEPTH
//   Tx_overflow  : sticky, a write was dropped
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 32'd50_000_000,
  parameter int          DATA_BITS = 32'sd8,
  parameter int          PARITY    = 32'sd0,
  parameter int          STOP_BITS = 32'sd1,
  parameter int          DEPTH     = 32'sd4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Tx_en,
  input  logic                   Tx_wr,
  input  logic [DATA_BITS-1:0]   Tx_data,
  input  logic [2:0]             baud_sel,
  output logic                   Tx_D,
  output logic                   Tx_busy,
  output logic                   Tx_full,
  output logic                   Tx_empty,
  output logic [$clog2(DEPTH):0] Tx_level,
  output logic                   Tx_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic                 r_overflow;

  tx_state_e            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_bit_cnt;
  logic                 r_par;
  logic                 r_tx_d;
  logic                 r_busy;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_tick;
  logic [31:0]          w_div;
  logic [DATA_BITS-1:0] w_head;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == {LVL_W{1'b0}});
  assign w_head  = r_mem[r_rd_ptr];
  // A pop frees a slot in the same cycle, so a write to a full FIFO
  // is accepted when a frame is starting.
  assign w_pop   = (r_state == ST_IDLE) & Tx_en & ~w_empty;
  assign w_push  = Tx_wr & (~w_full | w_pop);
  assign w_div   = baud_div(baud_sel, CLK_FREQ);

  uart_baud_gen u_baud (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load     (w_pop),
    .i_run      (r_state != ST_IDLE),
    .i_div      (w_div),
    .o_bit_tick (w_tick)
  );

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= Tx_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_level    <= {LVL_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (Tx_wr && !w_push) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
    end
  end

  // Frame sequencer: pops the head, walks the bit cells and drives the line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= {DATA_BITS{1'b0}};
      r_bit_cnt <= 4'd0;
      r_par     <= 1'b0;
      r_tx_d    <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_par   <= parity_bit(9'(w_head), DATA_BITS, PARITY);
            r_tx_d  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end else begin
            r_tx_d  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx_d    <= r_shift[0];
            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= 4'd0;
            r_state   <= ST_DATA;
          end else begin
            r_state   <= ST_START;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= 4'd0;
              if (PARITY != PAR_NONE) begin
                r_tx_d  <= r_par;
                r_state <= ST_PARITY;
              end else begin
                r_tx_d  <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_tx_d    <= r_shift[0];
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_state <= ST_DATA;
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_tx_d    <= 1'b1;
            r_bit_cnt <= 4'd0;
            r_state   <= ST_STOP;
          end else begin
            r_state   <= ST_PARITY;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_STOP) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_state <= ST_STOP;
          end
        end
        default: begin
          r_tx_d  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Tx_D        = r_tx_d;
  assign Tx_busy     = r_busy;
  assign Tx_full     = w_full;
  assign Tx_empty    = w_empty;
  assign Tx_level    = r_level;
  assign Tx_overflow = r_overflow;

endmodule
